// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master: operand source + result consumer; slave: the adder itself.
// The overflow signal exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, busy, overflow
    );
`else
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
`endif

endinterface : serial_adder_if

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell: the per-bit combinational stage of the
// serial adder.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule : serial_adder_fa

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. Operands are accepted in IDLE, processed
// LSB-first one bit per clock in SHIFT, and the result is held in DONE
// until the consumer takes it.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN (signed overflow output).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             carry_out_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             fa_sum_s;
    logic             fa_carry_s;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow_r;
`endif

    serial_adder_fa u_fa (
        .a     (op_a_r[0]),
        .b     (op_b_r[0]),
        .cin   (carry_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Sequencing FSM plus all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            op_a_r      <= '0;
            op_b_r      <= '0;
            sum_r       <= '0;
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        op_a_r     <= bus.a;
                        op_b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r    <= bus.sub;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    op_a_r  <= op_a_r >> 1;
                    op_b_r  <= op_b_r >> 1;
                    sum_r   <= (sum_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
                    carry_r <= fa_carry_s;
                    if (cnt_r == LAST_CNT) begin
                        carry_out_r <= fa_carry_s;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // Carry into the MSB is carry_r; carry out of it is fa_carry_s.
                        overflow_r  <= carry_r ^ fa_carry_s;
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + CNT_W'(1);
                        state_r     <= SHIFT;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.busy      = busy_r;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.overflow  = overflow_r;
`endif

endmodule : serial_adder
